// File: rtl/ifm_stream_packer_128.sv
// Packs a 32-bit valid/ready word stream into 128-bit IFM BRAM write beats, one frame per start pulse.
// Optional IFM_PAD_FLUSH_EN: flush a final partial beat with zero-filled lanes instead of dropping the tail.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; latches base_addr/num_words
// S_FILL  | accepting stream words into lanes 0..3
// S_WRITE | one-cycle BRAM write strobe for the packed beat
// S_DONE  | one-cycle done pulse, then back to idle
module ifm_stream_packer_128 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   num_words,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    wr_rd_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [4*DATA_WIDTH-1:0] data_in,
  output logic                    busy,
  output logic                    done
);

  localparam int BEAT_W = 4 * DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] beat_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [1:0]            idx_q;
  logic [BEAT_W-1:0]     lanes_q;
  logic [BEAT_W-1:0]     lanes_next;
  logic [BEAT_W-1:0]     data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] frame_len;
  logic                  accept;
  logic                  last_word;

`ifdef IFM_PAD_FLUSH_EN
  assign frame_len = num_words;
`else
  // Without flushing, the trailing 1-3 words are never requested.
  assign frame_len = num_words & ~ADDR_WIDTH'(3);
`endif

  assign accept    = s_valid && (state == S_FILL);
  assign last_word = (idx_q == 2'd3) || (rem_q == ADDR_WIDTH'(1));

  always_comb begin
    lanes_next = lanes_q;
    for (int i = 0; i < 4; i++) begin
      if (idx_q == i[1:0]) lanes_next[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      lanes_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            rem_q   <= frame_len;
            beat_q  <= '0;
            idx_q   <= '0;
            lanes_q <= '0;
            state   <= (frame_len == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            lanes_q <= lanes_next;
            idx_q   <= idx_q + 2'd1;
            rem_q   <= rem_q - ADDR_WIDTH'(1);
            if (last_word) begin
              data_q <= lanes_next;
              addr_q <= base_q + (beat_q << 2);
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // Clearing lanes here is what zero-fills a flushed partial beat.
          beat_q  <= beat_q + ADDR_WIDTH'(1);
          idx_q   <= '0;
          lanes_q <= '0;
          state   <= (rem_q == '0) ? S_DONE : S_FILL;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s_ready  = (state == S_FILL);
  assign wr_rd_en = (state == S_WRITE);
  assign busy     = (state == S_FILL) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign wr_addr  = addr_q;
  assign data_in  = data_q;

endmodule

// File: tb/tb_ifm_stream_packer_128.sv
// Directed bench for ifm_stream_packer_128; expectations follow IFM_PAD_FLUSH_EN when defined.
module tb_ifm_stream_packer_128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [31:0]  num_words = '0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         wr_rd_en;
  logic [31:0]  wr_addr;
  logic [127:0] data_in;
  logic         busy;
  logic         done;

  int vectors = 0;
  int errs = 0;

  int           nwr, ndone, done_cyc, acc, rdy_viol;
  logic         busy1;
  logic [31:0]  wa [8];
  logic [127:0] wd [8];
  int           wc [8];

  ifm_stream_packer_128 dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .wr_rd_en(wr_rd_en),
    .wr_addr(wr_addr), .data_in(data_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one frame; inputs change on negedge, outputs are sampled there too.
  task automatic run_frame(input logic [31:0] base, input logic [31:0] num, input int nsend,
                           input logic [31:0] w0, input bit toggle, input int mid_start,
                           input int rst_after);
    int cyc, post, rst_cnt;
    nwr = 0; ndone = 0; done_cyc = -1; acc = 0; rdy_viol = 0; busy1 = 1'b0;
    @(negedge clk);
    base_addr = base; num_words = num; start = 1'b1; s_valid = 1'b0;
    cyc = 0; post = 0; rst_cnt = 0;
    while (cyc < 300 && post < 4) begin
      @(negedge clk);
      cyc++;
      if (wr_rd_en) begin
        if (nwr < 8) begin
          wa[nwr] = wr_addr; wd[nwr] = data_in; wc[nwr] = cyc;
        end
        nwr++;
        if (s_ready) rdy_viol++;
      end
      if (done) begin
        ndone++; done_cyc = cyc;
      end
      if (cyc == 1) busy1 = busy;
      if (ndone > 0 || rst_cnt >= 2) post++;
      start = (cyc == mid_start);
      if (start) begin
        base_addr = 32'h300; num_words = 32'd8;
      end
      if (rst_after >= 0 && acc == rst_after && rst_cnt < 2) begin
        rst = 1'b1; rst_cnt++;
      end else begin
        rst = 1'b0;
      end
      s_valid = !rst && (acc < nsend) && (!toggle || cyc[0]);
      s_data  = w0 + 32'(acc);
      if (s_valid && s_ready) acc++;
    end
    start = 1'b0; s_valid = 1'b0; rst = 1'b0;
  endtask

  initial begin
    // 1. reset with s_valid asserted
    rst = 1'b1; s_valid = 1'b1; s_data = 32'hdead_beef;
    repeat (2) begin
      @(negedge clk);
      chk("rst_s_ready", 128'(s_ready), 128'd0);
      chk("rst_wr_rd_en", 128'(wr_rd_en), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
    end
    chk("rst_wr_addr", 128'(wr_addr), 128'd0);
    chk("rst_data_in", data_in, 128'd0);
    rst = 1'b0; s_valid = 1'b0;

    // 2. two full beats, s_valid always high
    run_frame(32'h100, 32'd8, 8, 32'h11, 1'b0, -1, -1);
    chk("f2_nwr", 128'(nwr), 128'd2);
    chk("f2_addr0", 128'(wa[0]), 128'h100);
    chk("f2_data0", wd[0], 128'h00000014_00000013_00000012_00000011);
    chk("f2_addr1", 128'(wa[1]), 128'h104);
    chk("f2_data1", wd[1], 128'h00000018_00000017_00000016_00000015);
    chk("f2_ndone", 128'(ndone), 128'd1);
    chk("f2_done_lat", 128'(done_cyc), 128'(wc[1] + 1));
    chk("f2_wr_lat", 128'(wc[0]), 128'd5);
    chk("f2_busy", 128'(busy1), 128'd1);
    chk("f2_acc", 128'(acc), 128'd8);
    chk("f2_idle_busy", 128'(busy), 128'd0);

    // 3. same frame, s_valid toggling
    run_frame(32'h100, 32'd8, 8, 32'h11, 1'b1, -1, -1);
    chk("f3_nwr", 128'(nwr), 128'd2);
    chk("f3_addr0", 128'(wa[0]), 128'h100);
    chk("f3_data0", wd[0], 128'h00000014_00000013_00000012_00000011);
    chk("f3_addr1", 128'(wa[1]), 128'h104);
    chk("f3_data1", wd[1], 128'h00000018_00000017_00000016_00000015);
    chk("f3_acc", 128'(acc), 128'd8);
    chk("f3_rdy_in_write", 128'(rdy_viol), 128'd0);
    chk("f3_ndone", 128'(ndone), 128'd1);

    // 4. six-word frame
    run_frame(32'h0, 32'd6, 6, 32'h21, 1'b0, -1, -1);
    chk("f4_addr0", 128'(wa[0]), 128'h0);
    chk("f4_data0", wd[0], 128'h00000024_00000023_00000022_00000021);
    chk("f4_ndone", 128'(ndone), 128'd1);
`ifdef IFM_PAD_FLUSH_EN
    chk("f4_nwr", 128'(nwr), 128'd2);
    chk("f4_acc", 128'(acc), 128'd6);
    chk("f4_addr1", 128'(wa[1]), 128'h4);
    chk("f4_data1", wd[1], 128'h00000000_00000000_00000026_00000025);
`else
    chk("f4_nwr", 128'(nwr), 128'd1);
    chk("f4_acc", 128'(acc), 128'd4);
`endif

    // 5a. empty frame
    run_frame(32'h500, 32'd0, 4, 32'h61, 1'b0, -1, -1);
    chk("f5_nwr", 128'(nwr), 128'd0);
    chk("f5_done_lat", 128'(done_cyc), 128'd1);
    chk("f5_ndone", 128'(ndone), 128'd1);
    chk("f5_acc", 128'(acc), 128'd0);

    // 5b. start mid-frame is ignored
    run_frame(32'h200, 32'd4, 8, 32'h31, 1'b0, 2, -1);
    chk("f5b_nwr", 128'(nwr), 128'd1);
    chk("f5b_addr0", 128'(wa[0]), 128'h200);
    chk("f5b_data0", wd[0], 128'h00000034_00000033_00000032_00000031);
    chk("f5b_acc", 128'(acc), 128'd4);
    chk("f5b_ndone", 128'(ndone), 128'd1);

    // 6. reset after two words of a beat, then a fresh frame
    run_frame(32'h80, 32'd4, 4, 32'h51, 1'b0, -1, 2);
    chk("f6_nwr", 128'(nwr), 128'd0);
    chk("f6_ndone", 128'(ndone), 128'd0);
    chk("f6_busy", 128'(busy), 128'd0);
    chk("f6_s_ready", 128'(s_ready), 128'd0);
    run_frame(32'h40, 32'd4, 4, 32'h41, 1'b0, -1, -1);
    chk("f6b_nwr", 128'(nwr), 128'd1);
    chk("f6b_addr0", 128'(wa[0]), 128'h40);
    chk("f6b_data0", wd[0], 128'h00000044_00000043_00000042_00000041);
    chk("f6b_ndone", 128'(ndone), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
